// File: rtl/dot_prod_feeder.sv
// Operand server and result collector for the column-serial dot_prod engine.
// Loads weights/inputs from a serial stream, serves column reads, captures the result.
module dot_prod_feeder #(
    parameter int NROW          = 16,
    parameter int NCOL          = 4,
    parameter int QN            = 6,
    parameter int QM            = 11,
    parameter int BITWIDTH      = QN + QM + 1,
    parameter int ADDR_BITWIDTH = (NCOL > 1) ? $clog2(NCOL) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         reload_weights,
    output logic                         busy,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [BITWIDTH-1:0]          wr_data,
    output logic                         dp_reset,
    input  logic [ADDR_BITWIDTH-1:0]     dp_colAddress,
    output logic [BITWIDTH*NROW-1:0]     dp_weightRow,
    output logic [BITWIDTH-1:0]          dp_inputVector,
    input  logic                         dp_dataReadyF,
    input  logic [BITWIDTH*NROW-1:0]     dp_outputVector,
    output logic [BITWIDTH*NROW-1:0]     result,
    output logic                         result_valid,
    input  logic                         result_ready
);

    localparam int RW = (NROW > 1) ? $clog2(NROW) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(NROW - 1);
    localparam logic [ADDR_BITWIDTH-1:0] COL_LAST = ADDR_BITWIDTH'(NCOL - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

    state_t state, state_nx;

    logic                     weights_valid;
    logic                     need_w;
    logic [RW-1:0]            row_cnt;
    logic [ADDR_BITWIDTH-1:0] col_cnt;
    logic                     wr_fire;
    logic                     load_last;
    logic                     addr_ok;
    logic [BITWIDTH*NROW-1:0] rd_col;

    logic [BITWIDTH-1:0] wmem [NCOL][NROW];
    logic [BITWIDTH-1:0] imem [NCOL];

    assign wr_fire   = wr_valid && (state == LOAD);
    // need_w clears once the weight block is in, so the final input word ends the stream
    assign load_last = wr_fire && !need_w && (col_cnt == COL_LAST);
    assign addr_ok   = {1'b0, dp_colAddress} < (ADDR_BITWIDTH + 1)'(NCOL);

    always_comb begin
        state_nx     = state;
        busy         = (state != IDLE);
        wr_ready     = (state == LOAD);
        dp_reset     = (state != RUN);
        result_valid = (state == HOLD);
        unique case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (load_last) state_nx = RUN;
            RUN:     if (dp_dataReadyF) state_nx = HOLD;
            HOLD:    if (result_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            weights_valid <= 1'b0;
            need_w        <= 1'b0;
            row_cnt       <= '0;
            col_cnt       <= '0;
            result        <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                need_w  <= reload_weights || !weights_valid;
                row_cnt <= '0;
                col_cnt <= '0;
            end
            if (wr_fire) begin
                if (need_w) begin
                    if (row_cnt == ROW_LAST) begin
                        row_cnt <= '0;
                        if (col_cnt == COL_LAST) begin
                            col_cnt <= '0;
                            need_w  <= 1'b0;
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end else if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
            if (load_last) weights_valid <= 1'b1;
            if (state == RUN && dp_dataReadyF) result <= dp_outputVector;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            if (need_w) wmem[col_cnt][row_cnt] <= wr_data;
            else        imem[col_cnt] <= wr_data;
        end
    end

    always_comb begin
        rd_col = '0;
        for (int r = 0; r < NROW; r++) begin
            rd_col[r*BITWIDTH +: BITWIDTH] = wmem[dp_colAddress][r];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_weightRow   <= '0;
            dp_inputVector <= '0;
        end else if (addr_ok) begin
            dp_weightRow   <= rd_col;
            dp_inputVector <= imem[dp_colAddress];
        end else begin
            dp_weightRow   <= '0;
            dp_inputVector <= '0;
        end
    end

endmodule

// File: tb/tb_dot_prod_feeder.sv
// Directed bench for dot_prod_feeder with a behavioural column-serial engine.
// Drives on the negedge, samples on the following negedge.
module tb_dot_prod_feeder;

    localparam int NROW = 16;
    localparam int NCOL = 4;
    localparam int QM   = 11;
    localparam int W    = 18;
    localparam int AW   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            reload_weights;
    logic            busy;
    logic            wr_valid;
    logic            wr_ready;
    logic [W-1:0]    wr_data;
    logic            dp_reset;
    logic [AW-1:0]   dp_colAddress;
    logic [W*NROW-1:0] dp_weightRow;
    logic [W-1:0]    dp_inputVector;
    logic            dp_dataReadyF;
    logic [W*NROW-1:0] dp_outputVector;
    logic [W*NROW-1:0] result;
    logic            result_valid;
    logic            result_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dot_prod_feeder dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .reload_weights (reload_weights),
        .busy           (busy),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .dp_reset       (dp_reset),
        .dp_colAddress  (dp_colAddress),
        .dp_weightRow   (dp_weightRow),
        .dp_inputVector (dp_inputVector),
        .dp_dataReadyF  (dp_dataReadyF),
        .dp_outputVector(dp_outputVector),
        .result         (result),
        .result_valid   (result_valid),
        .result_ready   (result_ready)
    );

    task automatic do_reset(input string name, input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        checks++;
        if (dp_reset !== 1'b1 || wr_ready !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_ctrl got dp_reset=%b wr_ready=%b busy=%b rv=%b want 1 0 0 0",
                     name, dp_reset, wr_ready, busy, result_valid);
        end
        checks++;
        if (result !== '0 || dp_weightRow !== '0 || dp_inputVector !== '0) begin
            errors++;
            $display("FAIL %s_data got result=%h wrow=%h in=%h want zeros",
                     name, result, dp_weightRow, dp_inputVector);
        end
        reset = 1'b0;
    endtask

    task automatic load_job(input string name, input bit rw, input int nw, input bit pattern,
                            input logic [W-1:0] wv, input logic [W-1:0] iv, input bit gaps,
                            input int abort_after);
        int k;
        int cyc;
        int hs;
        start = 1'b1;
        reload_weights = rw;
        @(negedge clk);
        start = 1'b0;
        reload_weights = 1'b0;
        checks++;
        if (wr_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready got wr_ready=%b busy=%b want 1 1", name, wr_ready, busy);
        end
        k = 0;
        hs = 0;
        cyc = 0;
        while (wr_ready === 1'b1 && cyc < 400) begin
            if (abort_after >= 0 && hs == abort_after) break;
            wr_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            if (k < nw)
                wr_data = pattern ? W'((k / NROW + 1) * (k % NROW + 1)) : wv;
            else if (k < nw + NCOL)
                wr_data = iv;
            else
                wr_data = 18'h00001;
            if (wr_valid) begin
                hs++;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0;
        if (abort_after < 0) begin
            checks++;
            if (hs != nw + NCOL) begin
                errors++;
                $display("FAIL %s_handshakes got %0d want %0d", name, hs, nw + NCOL);
            end
            checks++;
            if (dp_reset !== 1'b0 || wr_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_run got dp_reset=%b wr_ready=%b busy=%b want 0 0 1",
                         name, dp_reset, wr_ready, busy);
            end
        end
    endtask

    task automatic run_engine(input string name, input bit pattern, input logic [W-1:0] wv,
                              input logic [W-1:0] iv, input int exp);
        int acc[NROW];
        int bad;
        int e;
        logic signed [W-1:0]   w;
        logic signed [W-1:0]   x;
        logic signed [2*W-1:0] p;
        logic [W-1:0]          ew;
        for (int r = 0; r < NROW; r++) acc[r] = 0;
        for (int c = 0; c < NCOL; c++) begin
            dp_colAddress = AW'(c);
            @(negedge clk);
            bad = 0;
            x = dp_inputVector;
            if (x !== iv) bad++;
            for (int r = 0; r < NROW; r++) begin
                w = dp_weightRow[r*W +: W];
                ew = pattern ? W'((c + 1) * (r + 1)) : wv;
                if (w !== ew) bad++;
                p = w * x;
                acc[r] += int'(p >>> QM);
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s_read col %0d got row0=%h row15=%h in=%h want row0=%h in=%h",
                         name, c, dp_weightRow[0 +: W], dp_weightRow[15*W +: W], dp_inputVector,
                         pattern ? W'(c + 1) : wv, iv);
            end
        end
        for (int r = 0; r < NROW; r++) dp_outputVector[r*W +: W] = W'(acc[r]);
        dp_dataReadyF = 1'b1;
        @(negedge clk);
        dp_dataReadyF = 1'b0;
        dp_outputVector = '0;
        checks++;
        if (result_valid !== 1'b1 || dp_reset !== 1'b1) begin
            errors++;
            $display("FAIL %s_hold got rv=%b dp_reset=%b want 1 1", name, result_valid, dp_reset);
        end
        bad = 0;
        for (int r = 0; r < NROW; r++) begin
            e = 0;
            if (pattern) begin
                for (int c = 0; c < NCOL; c++)
                    e += ((c + 1) * (r + 1) * int'($signed(iv))) >>> QM;
            end else begin
                e = exp;
            end
            if (result[r*W +: W] !== W'(e)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_result got row0=%h row15=%h (%0d bad) want row0=%h",
                     name, result[0 +: W], result[15*W +: W], bad,
                     pattern ? W'(NCOL * 1 / 4) : W'(exp));
        end
    endtask

    task automatic release_result(input string name);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_release got busy=%b rv=%b want 0 0", name, busy, result_valid);
        end
    endtask

    task automatic test_reset();
        do_reset("reset", 3);
    endtask

    task automatic test_full_load();
        load_job("full", 1'b1, 64, 1'b0, 18'd2048, 18'd512, 1'b0, -1);
        run_engine("full", 1'b0, 18'd2048, 18'd512, 2048);
        release_result("full");
    endtask

    task automatic test_backpressure();
        load_job("gaps", 1'b1, 64, 1'b0, 18'd2048, 18'd512, 1'b1, -1);
        run_engine("gaps", 1'b0, 18'd2048, 18'd512, 2048);
        release_result("gaps");
    endtask

    task automatic test_result_stall();
        logic [W*NROW-1:0] held;
        int bad;
        held = result;
        bad = 0;
        result_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                start = 1'b1;
                reload_weights = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            reload_weights = 1'b0;
            if (result_valid !== 1'b1 || busy !== 1'b1 || wr_ready !== 1'b0 || result !== held)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall got rv=%b busy=%b wr_ready=%b row0=%h want 1 1 0 %h",
                     result_valid, busy, wr_ready, result[0 +: W], held[0 +: W]);
        end
        release_result("stall");
    endtask

    task automatic test_inputs_only();
        load_job("inonly", 1'b0, 0, 1'b0, 18'd0, 18'h3FC00, 1'b0, -1);
        run_engine("inonly", 1'b0, 18'd2048, 18'h3FC00, -4096);
        test_result_stall();
    endtask

    task automatic test_reset_mid_load();
        load_job("abort", 1'b1, 64, 1'b0, 18'd2048, 18'd512, 1'b0, 30);
        do_reset("abort_reset", 2);
        load_job("forced", 1'b0, 64, 1'b0, 18'd2048, 18'd512, 1'b0, -1);
        run_engine("forced", 1'b0, 18'd2048, 18'd512, 2048);
        release_result("forced");
    endtask

    task automatic test_read_latency();
        load_job("pattern", 1'b1, 64, 1'b1, 18'd0, 18'd512, 1'b0, -1);
        run_engine("pattern", 1'b1, 18'd0, 18'd512, 0);
        release_result("pattern");
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        reload_weights = 1'b0;
        wr_valid = 1'b0;
        wr_data = '0;
        dp_colAddress = '0;
        dp_dataReadyF = 1'b0;
        dp_outputVector = '0;
        result_ready = 1'b0;
        test_reset();
        test_full_load();
        test_backpressure();
        test_inputs_only();
        test_reset_mid_load();
        test_read_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
